score_button_conditioner: RTL

Converts the three raw scoreboard pushbuttons (increment, decrement, clear) into clean single-cycle inc/dec/clr pulses for the 2-digit BCD score counter directly downstream. Per button it synchronizes, debounces and edge-detects the input. Increment and decrement also get hold-to-auto-repeat. It arbitrates conflicts, so the counter never sees clr together with inc/dec, or inc together with dec.

---
 rtl/score_button_conditioner.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/score_button_conditioner.sv
// score_button_conditioner
//
// Turns the three raw scoreboard pushbuttons into clean one-cycle pulses for
// the 2-digit BCD score counter. Each button is synchronized (2 flops),
// debounced (counter based) and rising-edge detected (registered). The
// increment and decrement buttons also auto-repeat while held. Conflicting
// events are arbitrated so that clr never coincides with inc/dec and inc
// never coincides with dec.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   btn_inc_raw  in   asynchronous raw increment button, active-high
//   btn_dec_raw  in   asynchronous raw decrement button, active-high
//   btn_clr_raw  in   asynchronous raw clear button, active-high
//   inc          out  registered one-cycle increment pulse
//   dec          out  registered one-cycle decrement pulse
//   clr          out  registered one-cycle clear pulse
//
// Latency from a clean raw rise to the output pulse is DEBOUNCE_CYCLES+4
// edges: 2 sync + DEBOUNCE_CYCLES debounce + 1 edge detect + 1 output reg.

module score_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_raw,
    input  logic btn_dec_raw,
    input  logic btn_clr_raw,
    output logic inc,
    output logic dec,
    output logic clr
);

    // Button lane indices: 0 = inc, 1 = dec, 2 = clr.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [2:0] raw;
    assign raw = {btn_clr_raw, btn_dec_raw, btn_inc_raw};

    // Synchronizer, debounce and edge-detect state for all three buttons.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       deb_q, deb_d;
    logic [2:0]       deb_prev_q, deb_prev_d;
    logic [2:0]       rise_q, rise_d;
    logic [CNT_W-1:0] deb_cnt_q [3];
    logic [CNT_W-1:0] deb_cnt_d [3];

    // Repeat FSMs for inc and dec only.
    rep_state_e       state_q [2];
    rep_state_e       state_d [2];
    logic [CNT_W-1:0] rep_cnt_q [2];
    logic [CNT_W-1:0] rep_cnt_d [2];

    // Registered outputs.
    logic inc_q, inc_d;
    logic dec_q, dec_d;
    logic clr_q, clr_d;

    logic [1:0] ev;
    logic       clr_ev;
    logic       hold_conflict;

    // Both inc and dec held: neither may run its repeat timer.
    assign hold_conflict = deb_q[0] & deb_q[1];

    // Synchronizer, debounce and registered rising-edge detect.
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        rise_d     = deb_q & ~deb_prev_q;
        for (int i = 0; i < 3; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                // Any return to the debounced level restarts the count.
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    // Raw events and arbitration into the output registers.
    always_comb begin
        ev = 2'b00;
        for (int j = 0; j < 2; j++) begin
            case (state_q[j])
                ST_IDLE:   ev[j] = rise_q[j];
                ST_DELAY:  ev[j] = deb_q[j] & ~hold_conflict &
                                   (rep_cnt_q[j] == DELAY_LAST);
                ST_REPEAT: ev[j] = deb_q[j] & ~hold_conflict &
                                   (rep_cnt_q[j] == PERIOD_LAST);
                default:   ev[j] = 1'b0;
            endcase
        end
        clr_ev = rise_q[2];
        inc_d  = ev[0] & ~ev[1] & ~clr_ev;
        dec_d  = ev[1] & ~ev[0] & ~clr_ev;
        clr_d  = clr_ev;
    end

    // Repeat FSM next-state. A press whose pulse was dropped by arbitration
    // does not arm the repeat timer, so a suppressed press never repeats.
    always_comb begin
        logic [1:0] accepted;
        accepted = {dec_d, inc_d};
        for (int j = 0; j < 2; j++) begin
            state_d[j]   = state_q[j];
            rep_cnt_d[j] = rep_cnt_q[j];
            if (hold_conflict) begin
                state_d[j]   = ST_IDLE;
                rep_cnt_d[j] = '0;
            end else begin
                case (state_q[j])
                    ST_IDLE: begin
                        rep_cnt_d[j] = '0;
                        if (rise_q[j] && accepted[j]) begin
                            state_d[j] = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (!deb_q[j]) begin
                            state_d[j]   = ST_IDLE;
                            rep_cnt_d[j] = '0;
                        end else if (rep_cnt_q[j] == DELAY_LAST) begin
                            state_d[j]   = ST_REPEAT;
                            rep_cnt_d[j] = '0;
                        end else begin
                            rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!deb_q[j]) begin
                            state_d[j]   = ST_IDLE;
                            rep_cnt_d[j] = '0;
                        end else if (rep_cnt_q[j] == PERIOD_LAST) begin
                            rep_cnt_d[j] = '0;
                        end else begin
                            rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[j]   = ST_IDLE;
                        rep_cnt_d[j] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            rise_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
            for (int j = 0; j < 2; j++) begin
                state_q[j]   <= ST_IDLE;
                rep_cnt_q[j] <= '0;
            end
            inc_q <= 1'b0;
            dec_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            rise_q     <= rise_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            for (int j = 0; j < 2; j++) begin
                state_q[j]   <= state_d[j];
                rep_cnt_q[j] <= rep_cnt_d[j];
            end
            inc_q <= inc_d;
            dec_q <= dec_d;
            clr_q <= clr_d;
        end
    end

    assign inc = inc_q;
    assign dec = dec_q;
    assign clr = clr_q;

endmodule
